// File: rtl/freq_meter_if.sv
// Measurement bus of freq_meter: square-wave input plus the period result outputs.
interface freq_meter_if #(
    parameter int WIDTH = 32
);
    logic             i_sig;
    logic [WIDTH-1:0] o_period;
    logic             o_valid;
    logic             o_timeout;
    logic [3:0]       o_led;

    modport master (output i_sig, input o_period, o_valid, o_timeout, o_led);
    modport slave  (input i_sig, output o_period, o_valid, o_timeout, o_led);
endinterface

// File: rtl/freq_meter.sv
// Period meter: counts i_clk cycles between synchronized rising edges of i_sig,
// abandoning a measurement once it exceeds TIMEOUT cycles.
module freq_meter #(
    parameter int     WIDTH     = 32,
    parameter int     CLOCK_HZ  = 50_000_000,
    parameter longint TIMEOUT   = CLOCK_HZ,
    parameter int     LED_SHIFT = 22
) (
    input  logic         i_clk,
    input  logic         i_reset,
    freq_meter_if.slave  io_bus
);
    localparam logic [WIDTH-1:0] LP_TIMEOUT = WIDTH'(TIMEOUT);
    localparam logic [WIDTH-1:0] LP_ONE     = WIDTH'(1);

    typedef enum logic {S_IDLE, S_MEASURE} state_t;

    state_t           r_state, w_state_nxt;
    logic             r_sync_p0, r_sync_p1, r_prev_p2;
    logic             w_rise;
    logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0] r_period, w_period_nxt;
    logic             r_valid, w_valid_nxt;
    logic             r_timeout, w_timeout_nxt;
    logic [3:0]       r_led;

    // Stage p0/p1: two-flop synchronizer; p2: previous sample for edge detect
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync_p0 <= 1'b0;
            r_sync_p1 <= 1'b0;
            r_prev_p2 <= 1'b0;
        end else begin
            r_sync_p0 <= io_bus.i_sig;
            r_sync_p1 <= r_sync_p0;
            r_prev_p2 <= r_sync_p1;
        end
    end

    assign w_rise = r_sync_p1 & ~r_prev_p2;

    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    // A rise coinciding with counter == TIMEOUT is a valid measurement, not a timeout
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_valid_nxt   = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = LP_ONE;
                end
            end
            S_MEASURE: begin
                if (w_rise) begin
                    w_period_nxt = r_cnt;
                    w_valid_nxt  = 1'b1;
                    w_cnt_nxt    = LP_ONE;
                end else if (r_cnt == LP_TIMEOUT) begin
                    w_state_nxt   = S_IDLE;
                    w_timeout_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                end else begin
                    w_cnt_nxt = r_cnt + LP_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt     <= '0;
            r_period  <= '0;
            r_valid   <= 1'b0;
            r_timeout <= 1'b0;
            r_led     <= 4'h0;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_period  <= w_period_nxt;
            r_valid   <= w_valid_nxt;
            r_timeout <= w_timeout_nxt;
            r_led     <= r_period[LED_SHIFT +: 4];
        end
    end

    assign io_bus.o_period  = r_period;
    assign io_bus.o_valid   = r_valid;
    assign io_bus.o_timeout = r_timeout;
    assign io_bus.o_led     = r_led;
endmodule

// File: tb/tb_freq_meter.sv
// Bench for freq_meter: directed waveforms plus random pulse trains, checked
// cycle by cycle against an edge-timestamp reference model.
module tb_freq_meter;
    localparam int W      = 16;
    localparam int TO     = 100;
    localparam int LSH    = 2;
    localparam int NEV    = 16384;
    localparam int LAT    = 2;

    logic clk;
    logic rst;

    freq_meter_if #(.WIDTH(W)) bus();

    freq_meter #(
        .WIDTH(W), .CLOCK_HZ(1000), .TIMEOUT(TO), .LED_SHIFT(LSH)
    ) dut (
        .i_clk(clk),
        .i_reset(rst),
        .io_bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: timestamps of input rises sampled at clock edges
    int          n = 0;
    bit          armed = 0;
    int          last = 0;
    bit          prev_s = 0;
    logic [W-1:0] exp_period = '0;
    logic [3:0]  exp_led = '0;
    bit          exp_vld = 0;
    bit          exp_to = 0;
    bit          ev_v [NEV];
    bit          ev_t [NEV];
    int          ev_per [NEV];

    int ph_k = 0, ph_v = 0, ph_t = 0, tout_k = -1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic step(input bit s, input bit r);
        bit rise;
        @(negedge clk);
        bus.i_sig = s;
        rst = r;
        @(posedge clk);
        n++;
        if (r) begin
            armed = 0; prev_s = 0;
            exp_period = '0; exp_led = '0; exp_vld = 0; exp_to = 0;
            for (int j = 0; j <= LAT; j++) begin
                ev_v[n+j] = 0; ev_t[n+j] = 0;
            end
        end else begin
            exp_led = exp_period[LSH +: 4];
            exp_vld = ev_v[n];
            exp_to  = ev_t[n];
            if (ev_v[n]) exp_period = W'(ev_per[n]);
            rise   = s & ~prev_s;
            prev_s = s;
            if (rise) begin
                if (armed) begin
                    ev_v[n+LAT]   = 1;
                    ev_per[n+LAT] = n - last;
                end
                armed = 1;
                last  = n;
            end else if (armed && (n - last == TO)) begin
                ev_t[n+LAT] = 1;
                armed = 0;
            end
        end
        #1;
        chk("valid",   32'(bus.o_valid),   32'(exp_vld));
        chk("timeout", 32'(bus.o_timeout), 32'(exp_to));
        chk("period",  32'(bus.o_period),  32'(exp_period));
        chk("led",     32'(bus.o_led),     32'(exp_led));
        chk("excl",    32'(bus.o_valid & bus.o_timeout), 32'd0);
        if (bus.o_valid) ph_v++;
        if (bus.o_timeout) begin
            ph_t++;
            tout_k = ph_k;
        end
        ph_k++;
    endtask

    task automatic do_reset();
        step(0, 1);
        ph_k = 0; ph_v = 0; ph_t = 0; tout_k = -1;
    endtask

    initial begin
        int hi, lo;
        rst = 1'b1;
        bus.i_sig = 1'b0;
        for (int i = 0; i < NEV; i++) begin
            ev_v[i] = 0; ev_t[i] = 0; ev_per[i] = 0;
        end

        do_reset();
        chk("rst_period", 32'(bus.o_period), 32'd0);
        chk("rst_led",    32'(bus.o_led),    32'd0);

        // Square wave, period 10, six periods
        do_reset();
        for (int k = 0; k < 60; k++) step((k % 10) < 5, 0);
        chk("sq10_nvalid", ph_v, 5);
        chk("sq10_ntout",  ph_t, 0);
        chk("sq10_period", 32'(bus.o_period), 32'd10);

        // Single rise then held low: exactly one timeout
        do_reset();
        for (int k = 0; k < 5; k++)   step(1, 0);
        for (int k = 0; k < 130; k++) step(0, 0);
        chk("to_count",  ph_t, 1);
        chk("to_at",     tout_k, LAT + TO);
        chk("to_nvalid", ph_v, 0);
        chk("to_period", 32'(bus.o_period), 32'd0);

        // Rises exactly TIMEOUT apart
        do_reset();
        for (int k = 0; k < 400; k++) step((k % 100) < 10, 0);
        chk("edge_nvalid", ph_v, 3);
        chk("edge_ntout",  ph_t, 0);
        chk("edge_period", 32'(bus.o_period), 32'(TO));

        // Period-50 wave with a one-cycle reset 20 cycles after a rise
        do_reset();
        for (int k = 0; k < 200; k++) step((k % 50) < 10, k == 70);
        chk("rstmid_nvalid", ph_v, 2);
        chk("rstmid_period", 32'(bus.o_period), 32'd50);

        // Period 0x34 for the LED slice
        do_reset();
        for (int k = 0; k < 160; k++) step((k % 52) < 26, 0);
        chk("led_period", 32'(bus.o_period), 32'd52);
        chk("led_value",  32'(bus.o_led),    32'hD);

        // Toggle every cycle: minimum period
        do_reset();
        for (int k = 0; k < 20; k++) step(k % 2 == 0, 0);
        chk("tog_nvalid", ph_v, 8);
        chk("tog_period", 32'(bus.o_period), 32'd2);

        // Input already high through reset
        step(1, 1);
        for (int k = 0; k < 30; k++) step((k % 12) >= 6, 0);

        // Random pulse trains with occasional resets
        for (int seg = 0; seg < 60; seg++) begin
            hi = $urandom_range(1, 60);
            lo = $urandom_range(1, 70);
            for (int k = 0; k < hi; k++) step(1, $urandom_range(0, 199) == 0);
            for (int k = 0; k < lo; k++) step(0, $urandom_range(0, 199) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
